// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: parity-checking receive FIFO (first-word-fall-through)
// with saturating parity-error and overflow counters.
module uart_rx_buffer #(
    parameter int N          = 8,
    parameter int DEPTH      = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N:0]               rx_data,
    input  logic                     rx_valid,
    output logic [N-1:0]             out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               perr_cnt,
    output logic [7:0]               ovf_cnt,
    output logic                     overflow,
    input  logic                     clear_errs
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [N-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [7:0]    r_perr_cnt;
    logic [7:0]    r_ovf_cnt;
    logic          r_overflow;

    logic w_parity_ok;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_perr;
    logic w_ovf;

    always_comb begin
        w_parity_ok = (^rx_data) == 1'(PARITY_ODD);
        w_full      = r_level == LW'(DEPTH);
        w_pop       = (r_level != '0) && out_ready;
        w_push      = rx_valid && w_parity_ok && (!w_full || w_pop);
        w_perr      = rx_valid && !w_parity_ok;
        w_ovf       = rx_valid && w_parity_ok && w_full && !w_pop;
    end

    // Storage is deliberately unreset; out_data is forced to 0 while empty instead.
    always_ff @(posedge clk) begin
        if (w_push && rst_n)
            r_mem[r_wr_ptr] <= rx_data[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_perr_cnt <= '0;
            r_ovf_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (clear_errs) begin
                r_perr_cnt <= '0;
                r_ovf_cnt  <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_perr && r_perr_cnt != 8'hFF)
                    r_perr_cnt <= r_perr_cnt + 8'd1;
                if (w_ovf && r_ovf_cnt != 8'hFF)
                    r_ovf_cnt <= r_ovf_cnt + 8'd1;
                if (w_ovf)
                    r_overflow <= 1'b1;
            end
        end
    end

    assign out_valid = r_level != '0;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign level     = r_level;
    assign perr_cnt  = r_perr_cnt;
    assign ovf_cnt   = r_ovf_cnt;
    assign overflow  = r_overflow;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed self-checking bench for uart_rx_buffer
// (N=8, DEPTH=8, even parity).
module tb_uart_rx_buffer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] level;
    logic [7:0] perr_cnt;
    logic [7:0] ovf_cnt;
    logic       overflow;
    logic       clear_errs;

    int errors = 0;
    int checks = 0;

    uart_rx_buffer #(.N(8), .DEPTH(8), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .perr_cnt(perr_cnt), .ovf_cnt(ovf_cnt),
        .overflow(overflow), .clear_errs(clear_errs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs and checks happen 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a character with correct even parity (bit 8 = XOR of data).
    task automatic good(input logic [7:0] d);
        rx_data  = {^d, d};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic bad(input logic [7:0] d);
        rx_data  = {~(^d), d};
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];
        rst_n = 1'b0; rx_data = '0; rx_valid = 1'b0; out_ready = 1'b0; clear_errs = 1'b0;
        tick(); tick();
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_perr", 32'(perr_cnt), 0);
        chk("rst_ovf", 32'(ovf_cnt), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        tick();

        // Single character: visible only after the edge that writes it
        rx_data = 9'b0_10100101; rx_valid = 1'b1;
        #1;
        chk("no_bypass", 32'(out_valid), 0);
        tick();
        rx_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_level", 32'(level), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop_valid", 32'(out_valid), 0);
        chk("single_pop_level", 32'(level), 0);

        // Ready while empty has no effect
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("empty_ready_level", 32'(level), 0);

        // Parity error
        rx_data = 9'b1_10100101; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("perr_level", 32'(level), 0);
        chk("perr_cnt1", 32'(perr_cnt), 1);
        chk("perr_no_ovf", 32'(overflow), 0);

        // Overflow: nine characters into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) good(8'(i));
        chk("ovf_level", 32'(level), 8);
        chk("ovf_cnt1", 32'(ovf_cnt), 1);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", 32'(out_data), 32'h01);

        // Push and pop while full: 01 leaves, 0A enters behind 02..08
        out_ready = 1'b1;
        good(8'h0A);
        out_ready = 1'b0;
        chk("full_pp_level", 32'(level), 8);
        chk("full_pp_ovf", 32'(ovf_cnt), 1);
        for (int i = 2; i <= 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h0A);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), 32'(out_data), 32'(exp_q[i]));
            tick();
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(level), 0);
        chk("drain_valid", 32'(out_valid), 0);

        // Push and pop at level 1
        good(8'h55);
        out_ready = 1'b1;
        good(8'h66);
        out_ready = 1'b0;
        chk("lvl1_pp_level", 32'(level), 1);
        chk("lvl1_pp_data", 32'(out_data), 32'h66);

        // Clear coincident with a parity error; FIFO untouched
        bad(8'h12);
        bad(8'h34);
        chk("perr_cnt3", 32'(perr_cnt), 3);
        clear_errs = 1'b1;
        bad(8'h56);
        clear_errs = 1'b0;
        chk("clr_perr", 32'(perr_cnt), 0);
        chk("clr_ovf", 32'(ovf_cnt), 0);
        chk("clr_overflow", 32'(overflow), 0);
        chk("clr_level", 32'(level), 1);
        chk("clr_data", 32'(out_data), 32'h66);

        // Saturation of perr_cnt after 300 errors
        for (int i = 0; i < 300; i++) bad(8'(i));
        chk("perr_sat", 32'(perr_cnt), 255);
        chk("perr_sat_level", 32'(level), 1);

        // Saturation of ovf_cnt: fill (7 more) then 260 drops
        for (int i = 0; i < 7; i++) good(8'(i));
        for (int i = 0; i < 260; i++) good(8'hEE);
        chk("ovf_sat", 32'(ovf_cnt), 255);
        chk("ovf_sat_flag", 32'(overflow), 1);
        chk("ovf_sat_level", 32'(level), 8);

        // Clear, drain, then set up level 5 for a mid-stream reset
        clear_errs = 1'b1;
        tick();
        clear_errs = 1'b0;
        chk("clr2_ovf", 32'(ovf_cnt), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        out_ready = 1'b0;
        chk("clr2_level", 32'(level), 0);
        for (int i = 0; i < 5; i++) good(8'(8'h20 + i));
        chk("pre_rst_level", 32'(level), 5);
        #2 rst_n = 1'b0;
        #0.5;
        chk("async_rst_level", 32'(level), 0);
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_data", 32'(out_data), 0);
        #0.5 rst_n = 1'b1;
        tick();
        good(8'h3C);
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_data", 32'(out_data), 32'h3C);
        chk("post_rst_level", 32'(level), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter N, default 8, meaning data bits per UART character.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter PARITY_ODD, default 0, meaning 0 = even parity and 1 = odd parity.
REQ-004 SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port rx_data  input  N+1  meaning received character from the UART receiver; bit N = parity bit, bits N-1:0 = data.
REQ-007 SHALL have port rx_valid  input  1  meaning one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port out_data  output  N  meaning head-of-FIFO data word (first-word-fall-through).
REQ-009 SHALL have port out_valid  output  1  meaning FIFO non-empty; out_data is valid.
REQ-010 SHALL have port out_ready  input  1  meaning consumer accepts out_data this cycle.
REQ-011 SHALL have port level  output  $clog2(DEPTH)+1  meaning current number of stored entries.
REQ-012 SHALL have port perr_cnt  output  8  meaning saturating count of parity-failed characters.
REQ-013 SHALL have port ovf_cnt  output  8  meaning saturating count of characters dropped because the FIFO is full.
REQ-014 SHALL have port overflow  output  1  meaning sticky flag, set on the first overflow drop.
REQ-015 SHALL have port clear_errs  input  1  meaning synchronous clear of perr_cnt, ovf_cnt and overflow.

Function
REQ-016 SHALL define parity check as: XOR of all N+1 rx_data bits equals PARITY_ODD; else parity error.
REQ-017 SHALL accept a character only when rx_valid=1, parity passes and (level<DEPTH or a pop occurs in the same cycle).
REQ-018 SHALL, on parity error with rx_valid=1, discard the character and increment perr_cnt; no FIFO write, no overflow effect.
REQ-019 SHALL, on parity pass with level==DEPTH and no same-cycle pop, discard the character, increment ovf_cnt and set overflow.
REQ-020 SHALL define pop as out_valid && out_ready; out_ready while empty has no effect.
REQ-021 SHALL drive out_valid = (level != 0) and out_data = stored word at the read pointer, both registered-state derived with no combinational path from rx_* inputs.
REQ-022 SHALL have latency of one cycle: an accepted write at edge k into an empty FIFO gives out_valid=1 after edge k; there is no same-cycle bypass.
REQ-023 SHALL, on simultaneous accepted write and pop, update both pointers and leave level unchanged, including when full and when level==1.
REQ-024 SHALL wrap read and write pointers modulo DEPTH; level distinguishes full from empty.
REQ-025 SHALL saturate perr_cnt and ovf_cnt at 255; further events leave them at 255; overflow stays 1.
REQ-026 SHALL give clear_errs priority over a same-cycle error event: the counters become 0 and overflow becomes 0.
REQ-027 SHALL NOT let clear_errs affect FIFO contents, pointers or level.
REQ-028 SHALL NOT let the stored data word include the parity bit.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously set pointers=0, level=0, out_valid=0, perr_cnt=0, ovf_cnt=0 and overflow=0; out_data becomes 0.
REQ-030 SHALL, on reset mid-operation, discard all stored entries; no write or pop occurs on the edge at which rst_n is low.
REQ-031 SHALL leave memory array contents unreset; out_data is don't-care while out_valid=0, except immediately after reset.

Verification
REQ-032 SHALL cover single character: N=8, even parity, rx_data=9'b0_10100101 with rx_valid pulse -> out_valid=1 next cycle, out_data=8'hA5, level=1; out_ready=1 -> empty next cycle.
REQ-033 SHALL cover parity error: rx_data=9'b1_10100101 -> no write, level=0, perr_cnt=1.
REQ-034 SHALL cover overflow: 9 valid characters 8'h01..8'h09 with out_ready=0 -> level=8, ovf_cnt=1, overflow=1; drain yields 01..08 in order.
REQ-035 SHALL cover full with push+pop: at level=8, rx_valid with out_ready=1 -> level stays 8, ovf_cnt unchanged, new word exits after the 7 remaining older words.
REQ-036 SHALL cover clear versus error: clear_errs=1 coincident with a parity error while perr_cnt=3 -> perr_cnt=0; perr_cnt saturates at 255 after 300 errors.
REQ-037 SHALL cover mid-stream reset: rst_n low for 1 ns between edges at level=5 -> level=0 and out_valid=0 immediately; the next valid character is received normally.
